// File: rtl/eth_rst_seq.sv
// PLL-lock qualified Ethernet PHY / core reset sequencer: WAIT_LOCK -> PHY_RST -> PHY_SETTLE -> RUN.
// Optional macro RST_SEQ_LOCK_WATCH_EN: lock loss after WAIT_LOCK drops the sequence back to WAIT_LOCK.
module eth_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned PHY_RST_CYCLES     = 1250000,
  parameter int unsigned PHY_SETTLE_CYCLES  = 6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       phy_rst_n,
  output logic       core_rst,
  output logic       ready,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_WAIT_LOCK  = 2'd0;
  localparam logic [1:0] S_PHY_RST    = 2'd1;
  localparam logic [1:0] S_PHY_SETTLE = 2'd2;
  localparam logic [1:0] S_RUN        = 2'd3;

  localparam int unsigned MAX_A = (LOCK_STABLE_CYCLES > PHY_RST_CYCLES) ? LOCK_STABLE_CYCLES : PHY_RST_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > PHY_SETTLE_CYCLES) ? MAX_A : PHY_SETTLE_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PHY_RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(PHY_SETTLE_CYCLES - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_next_state;
  logic          w_clr;

  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    case (r_state)
      S_WAIT_LOCK: begin
        if (!pll_locked) begin
          w_clr = 1'b1;
        end else if (r_cnt == LOCK_LAST) begin
          w_next_state = S_PHY_RST;
        end
      end
      default: begin
`ifdef RST_SEQ_LOCK_WATCH_EN
        if (!pll_locked) begin
          w_next_state = S_WAIT_LOCK;
          w_clr        = 1'b1;
        end else
`endif
        // restart from PHY_RST keeps the state, so the counter clear must be explicit
        if (restart) begin
          w_next_state = S_PHY_RST;
          w_clr        = 1'b1;
        end else if (r_state == S_PHY_RST && r_cnt == RST_LAST) begin
          w_next_state = S_PHY_SETTLE;
        end else if (r_state == S_PHY_SETTLE && r_cnt == SETTLE_LAST) begin
          w_next_state = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_WAIT_LOCK;
      r_cnt     <= '0;
      phy_rst_n <= 1'b0;
      core_rst  <= 1'b1;
      ready     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_clr || (w_next_state != r_state)) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // outputs decode the next state so they move on the same edge as state_o
      phy_rst_n <= (w_next_state == S_PHY_SETTLE) || (w_next_state == S_RUN);
      core_rst  <= (w_next_state != S_RUN);
      ready     <= (w_next_state == S_RUN);
    end
  end

  assign state_o = r_state;

endmodule
